// File: rtl/bp_cfg_link_pkg.sv
// Shared definitions for the configuration link: destination classes,
// register addresses, mode encodings and the loader state enum.
package bp_cfg_link_pkg;

   typedef enum logic [1:0] {
      e_cfg_core = 2'd0,
      e_cfg_lce  = 2'd1,
      e_cfg_cce  = 2'd2
   } bp_cfg_dst_e;

   typedef enum logic {
      e_lce_mode_uncached = 1'b0,
      e_lce_mode_normal   = 1'b1
   } bp_lce_mode_e;

   typedef enum logic {
      e_cce_mode_uncached = 1'b0,
      e_cce_mode_normal   = 1'b1
   } bp_cce_mode_e;

   localparam logic [15:0] cfg_freeze_addr     = 16'h0001;
   localparam logic [15:0] cfg_lce_mode_addr   = 16'h0004;
   localparam logic [15:0] cfg_cce_mode_addr   = 16'h0006;
   localparam logic [15:0] cfg_ucode_base_addr = 16'h8000;

   typedef enum logic [2:0] {
      e_reset,
      e_freeze,
      e_lce_mode,
      e_ucode_fetch,
      e_ucode_send,
      e_cce_mode,
      e_unfreeze,
      e_done
   } bp_cfg_loader_state_e;

   // Index width that never collapses to zero bits.
   function automatic int safe_clog2(input int x);
      return (x <= 1) ? 1 : $clog2(x);
   endfunction

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/bp_cfg_loader_counter.sv
// Clearable up-counter with a terminal-count flag against a runtime limit.
module bp_cfg_loader_counter
   import bp_cfg_link_pkg::*;
#(
   parameter int width_p = 1
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               clear_i,
   input  logic               inc_i,
   input  logic [width_p-1:0] max_i,
   output logic [width_p-1:0] count_o,
   output logic               last_o
);

   // Clear wins over increment so a state exit always restarts from zero.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i)      count_o <= '0;
      else if (clear_i) count_o <= '0;
      else if (inc_i)   count_o <= count_o + 1'b1;
   end

   assign last_o = (count_o == max_i);

endmodule

// File: rtl/bp_cfg_loader.sv
// Post-reset configuration sequencer: freeze cores, set LCE modes, stream
// CCE microcode from a ROM, set CCE modes, unfreeze, then report done.
// Link handshake: a write transfers on a rising clk edge where cfg_v_o and
// cfg_ready_i are both high; once cfg_v_o rises the payload holds until that
// edge, and cfg_v_o is a function of registered state only.
module bp_cfg_loader
   import bp_cfg_link_pkg::*;
#(
   parameter int num_core_p              = 1,
   parameter int num_lce_p               = 2,
   parameter int num_cce_p               = 1,
   parameter int num_cce_instr_ram_els_p = 256,
   parameter int cfg_addr_width_p        = 16,
   parameter int cfg_data_width_p        = 64,
   parameter int cfg_id_width_p          = safe_clog2(max3(num_core_p, num_lce_p, num_cce_p))
) (
   input  logic                                            clk_i,
   input  logic                                            reset_i,
   output logic [safe_clog2(num_cce_instr_ram_els_p)-1:0] ucode_addr_o,
   input  logic [cfg_data_width_p-1:0]                     ucode_data_i,
   output logic                                            cfg_v_o,
   output logic [1:0]                                      cfg_dst_o,
   output logic [cfg_id_width_p-1:0]                       cfg_id_o,
   output logic [cfg_addr_width_p-1:0]                     cfg_addr_o,
   output logic [cfg_data_width_p-1:0]                     cfg_data_o,
   input  logic                                            cfg_ready_i,
   output logic                                            done_o
);

   localparam int word_width_lp = safe_clog2(num_cce_instr_ram_els_p);

   localparam logic [cfg_id_width_p-1:0] core_last_lp = cfg_id_width_p'(num_core_p - 1);
   localparam logic [cfg_id_width_p-1:0] lce_last_lp  = cfg_id_width_p'(num_lce_p - 1);
   localparam logic [cfg_id_width_p-1:0] cce_last_lp  = cfg_id_width_p'(num_cce_p - 1);
   localparam logic [word_width_lp-1:0]  word_last_lp = word_width_lp'(num_cce_instr_ram_els_p - 1);

   bp_cfg_loader_state_e state_r, state_n;

   logic                        handshake;
   logic [cfg_id_width_p-1:0]   idx, idx_max;
   logic                        idx_last, idx_inc, idx_clr;
   logic [word_width_lp-1:0]    word;
   logic                        word_last, word_inc, word_clr;
   logic                        first_r;
   logic                        stage_en;
   logic [cfg_data_width_p-1:0] stage_r;

   assign handshake = cfg_v_o & cfg_ready_i;

   // Endpoint index within the current destination class.
   bp_cfg_loader_counter #(.width_p(cfg_id_width_p)) idx_cnt (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .clear_i (idx_clr),
      .inc_i   (idx_inc),
      .max_i   (idx_max),
      .count_o (idx),
      .last_o  (idx_last)
   );

   // Microcode word index; fetch/send form one phase, so it persists across
   // that pair and only clears after the last word of a CCE.
   bp_cfg_loader_counter #(.width_p(word_width_lp)) word_cnt (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .clear_i (word_clr),
      .inc_i   (word_inc),
      .max_i   (word_last_lp),
      .count_o (word),
      .last_o  (word_last)
   );

   // State register.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) state_r <= e_reset;
      else         state_r <= state_n;
   end

   // Marks the first send cycle, when the ROM word is on ucode_data_i.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) first_r <= 1'b0;
      else         first_r <= (state_r == e_ucode_fetch);
   end

   // Staging register: holds the ROM word so a stalled send never re-reads.
   assign stage_en = (state_r == e_ucode_send) & first_r;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i)       stage_r <= '0;
      else if (stage_en) stage_r <= ucode_data_i;
   end

   // Next state, link payload and counter controls.
   always_comb begin
      state_n      = state_r;
      cfg_v_o      = 1'b0;
      cfg_dst_o    = e_cfg_core;
      cfg_id_o     = '0;
      cfg_addr_o   = '0;
      cfg_data_o   = '0;
      ucode_addr_o = '0;
      done_o       = 1'b0;
      idx_max      = '0;
      idx_inc      = 1'b0;
      idx_clr      = 1'b0;
      word_inc     = 1'b0;
      word_clr     = 1'b0;
      case (state_r)
         e_reset: state_n = e_freeze;
         e_freeze: begin
            cfg_v_o    = 1'b1;
            cfg_dst_o  = e_cfg_core;
            cfg_id_o   = idx;
            cfg_addr_o = cfg_addr_width_p'(cfg_freeze_addr);
            cfg_data_o = cfg_data_width_p'(1'b1);
            idx_max    = core_last_lp;
            if (handshake) begin
               if (idx_last) begin idx_clr = 1'b1; state_n = e_lce_mode; end
               else          idx_inc = 1'b1;
            end
         end
         e_lce_mode: begin
            cfg_v_o    = 1'b1;
            cfg_dst_o  = e_cfg_lce;
            cfg_id_o   = idx;
            cfg_addr_o = cfg_addr_width_p'(cfg_lce_mode_addr);
            cfg_data_o = cfg_data_width_p'(e_lce_mode_normal);
            idx_max    = lce_last_lp;
            if (handshake) begin
               if (idx_last) begin idx_clr = 1'b1; state_n = e_ucode_fetch; end
               else          idx_inc = 1'b1;
            end
         end
         e_ucode_fetch: begin
            ucode_addr_o = word;
            idx_max      = cce_last_lp;
            state_n      = e_ucode_send;
         end
         e_ucode_send: begin
            cfg_v_o    = 1'b1;
            cfg_dst_o  = e_cfg_cce;
            cfg_id_o   = idx;
            cfg_addr_o = cfg_addr_width_p'(cfg_ucode_base_addr) + cfg_addr_width_p'(word);
            cfg_data_o = first_r ? ucode_data_i : stage_r;
            idx_max    = cce_last_lp;
            if (handshake) begin
               state_n = e_ucode_fetch;
               if (word_last) begin
                  word_clr = 1'b1;
                  if (idx_last) begin idx_clr = 1'b1; state_n = e_cce_mode; end
                  else          idx_inc = 1'b1;
               end else begin
                  word_inc = 1'b1;
               end
            end
         end
         e_cce_mode: begin
            cfg_v_o    = 1'b1;
            cfg_dst_o  = e_cfg_cce;
            cfg_id_o   = idx;
            cfg_addr_o = cfg_addr_width_p'(cfg_cce_mode_addr);
            cfg_data_o = cfg_data_width_p'(e_cce_mode_normal);
            idx_max    = cce_last_lp;
            if (handshake) begin
               if (idx_last) begin idx_clr = 1'b1; state_n = e_unfreeze; end
               else          idx_inc = 1'b1;
            end
         end
         e_unfreeze: begin
            cfg_v_o    = 1'b1;
            cfg_dst_o  = e_cfg_core;
            cfg_id_o   = idx;
            cfg_addr_o = cfg_addr_width_p'(cfg_freeze_addr);
            cfg_data_o = '0;
            idx_max    = core_last_lp;
            if (handshake) begin
               if (idx_last) begin idx_clr = 1'b1; state_n = e_done; end
               else          idx_inc = 1'b1;
            end
         end
         e_done: done_o = 1'b1;
         default: state_n = e_reset;
      endcase
   end

endmodule
